aes_sbox_share_sequencer: RTL

Time-shares one composite-field AES S-box (forward isomorphism, GF((2^4)^2) inversion, reverse isomorphism, affine) between two requesters: the round datapath (SubBytes, 16 bytes) and the key schedule (SubWord, 4 bytes). Each job is serialised through the S-box one byte per cycle, the results are collected by byte index, and the job returns as a whole word. The S-box sits outside this block and is a fixed-latency pipeline.

---
 rtl/aes_sbox_share_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_sbox_share_sequencer.sv
// ---------------------------------------------------------------------------
// aes_sbox_share_sequencer
//
// Shares one external fixed-latency AES S-box between two requesters. The
// round datapath submits a 16-byte SubBytes job and the key schedule submits
// a 4-byte SubWord job. A granted job is streamed through the S-box one byte
// per cycle. Results are gathered by byte index, and the job is returned as a
// whole word with a one-cycle done pulse.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   data_req/data_in/data_ack  SubBytes job request, 128-bit state, accept pulse
//   data_done/data_out         SubBytes completion pulse, held 128-bit result
//   key_req/key_in/key_ack     SubWord job request, 32-bit word, accept pulse
//   key_done/key_out           SubWord completion pulse, held 32-bit result
//   sbox_in/sbox_in_valid      byte issued to the S-box (zero when not valid)
//   sbox_out                   S-box result, SBOX_LATENCY cycles after issue
//   busy                       high in every state except IDLE
// ---------------------------------------------------------------------------
module aes_sbox_share_sequencer #(
  parameter int SBOX_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_req,
  input  logic [127:0] data_in,
  output logic         data_ack,
  output logic         data_done,
  output logic [127:0] data_out,
  input  logic         key_req,
  input  logic [31:0]  key_in,
  output logic         key_ack,
  output logic         key_done,
  output logic [31:0]  key_out,
  output logic [7:0]   sbox_in,
  output logic         sbox_in_valid,
  input  logic [7:0]   sbox_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_reg;
  state_t         state_next;

  logic           job_key_reg;   // owner of the job in flight: 1 = key, 0 = data
  logic           last_key_reg;  // owner of the most recent grant
  logic [127:0]   work_reg;
  logic [3:0]     idx_reg;
  logic [127:0]   result_reg;
  logic [127:0]   result_next;
  logic [127:0]   data_out_reg;
  logic [31:0]    key_out_reg;

  logic           grant_data;
  logic           grant_key;
  logic [3:0]     last_idx;
  logic           issue_last;
  logic           emerge_valid;
  logic [3:0]     emerge_idx;

  // If both requesters are active, the requester that was not granted last
  // wins. This gives strict alternation under sustained contention.
  assign grant_key  = key_req  & (~data_req | ~last_key_reg);
  assign grant_data = data_req & (~key_req  |  last_key_reg);

  assign last_idx   = job_key_reg ? 4'd3 : 4'd15;
  assign issue_last = (idx_reg == last_idx);

  // Delay line that tracks each issued byte's index alongside the S-box pipe.
  // The valid bit is cleared on reset, so results already inside the S-box
  // after an abandoned job are dropped.
  generate
    if (SBOX_LATENCY == 0) begin : g_no_delay
      assign emerge_valid = sbox_in_valid;
      assign emerge_idx   = idx_reg;
    end else begin : g_delay
      logic       pipe_valid_reg [SBOX_LATENCY];
      logic [3:0] pipe_idx_reg   [SBOX_LATENCY];
      for (genvar gi = 0; gi < SBOX_LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          always_ff @(posedge clk) begin
            if (reset) begin
              pipe_valid_reg[gi] <= 1'b0;
              pipe_idx_reg[gi]   <= 4'd0;
            end else begin
              pipe_valid_reg[gi] <= sbox_in_valid;
              pipe_idx_reg[gi]   <= idx_reg;
            end
          end
        end else begin : g_tail
          always_ff @(posedge clk) begin
            if (reset) begin
              pipe_valid_reg[gi] <= 1'b0;
              pipe_idx_reg[gi]   <= 4'd0;
            end else begin
              pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
              pipe_idx_reg[gi]   <= pipe_idx_reg[gi-1];
            end
          end
        end
      end
      assign emerge_valid = pipe_valid_reg[SBOX_LATENCY-1];
      assign emerge_idx   = pipe_idx_reg[SBOX_LATENCY-1];
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_data | grant_key) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_last) begin
          state_next = (SBOX_LATENCY == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (emerge_valid && (emerge_idx == last_idx)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM: outputs. Acks are suppressed while reset is high, so a request is
  // never acknowledged in a cycle where its capture is discarded.
  always_comb begin
    data_ack      = 1'b0;
    key_ack       = 1'b0;
    data_done     = 1'b0;
    key_done      = 1'b0;
    sbox_in_valid = 1'b0;
    sbox_in       = 8'd0;
    busy          = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        data_ack = grant_data & ~reset;
        key_ack  = grant_key  & ~reset;
      end
      ST_ISSUE: begin
        sbox_in_valid = 1'b1;
        sbox_in       = work_reg[{idx_reg, 3'b000} +: 8];
      end
      ST_DONE: begin
        data_done = ~job_key_reg;
        key_done  =  job_key_reg;
      end
      default: begin
      end
    endcase
  end

  // Scatter the S-box result into its byte lane. The published outputs load
  // from result_next, so the byte captured on the last cycle is included.
  always_comb begin
    result_next = result_reg;
    if (emerge_valid) begin
      result_next[{emerge_idx, 3'b000} +: 8] = sbox_out;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      job_key_reg  <= 1'b0;
      last_key_reg <= 1'b0;
      work_reg     <= '0;
      idx_reg      <= 4'd0;
      result_reg   <= '0;
      data_out_reg <= '0;
      key_out_reg  <= '0;
    end else begin
      result_reg <= result_next;
      case (state_reg)
        ST_IDLE: begin
          idx_reg <= 4'd0;
          if (grant_key) begin
            work_reg     <= {96'd0, key_in};
            job_key_reg  <= 1'b1;
            last_key_reg <= 1'b1;
          end else if (grant_data) begin
            work_reg     <= data_in;
            job_key_reg  <= 1'b0;
            last_key_reg <= 1'b0;
          end
        end
        ST_ISSUE: begin
          idx_reg <= idx_reg + 4'd1;
        end
        default: begin
        end
      endcase
      // DONE is only reached from ISSUE or DRAIN. Each output is therefore
      // loaded exactly once per job, on the edge that enters DONE.
      if (state_next == ST_DONE) begin
        if (job_key_reg) begin
          key_out_reg <= result_next[31:0];
        end else begin
          data_out_reg <= result_next;
        end
      end
    end
  end

  assign data_out = data_out_reg;
  assign key_out  = key_out_reg;

endmodule
